// File: rtl/cnt_mon_pkg.sv
// cnt_mon_pkg: state encoding, default widths and next-value prediction shared by counter_monitor.
package cnt_mon_pkg;
    typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;
    localparam int DEF_WIDTH = 6;
    localparam int DEF_ERR_W = 8;
    localparam int DEF_STEP_W = 16;
    function automatic logic [31:0] step_expect(input logic [31:0] prev, input logic up, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (up ? prev + 32'd1 : prev - 32'd1) & mask;
    endfunction
endpackage

// File: rtl/cnt_mon_stall_timer.sv
// cnt_mon_stall_timer: saturating idle timer; stall is high once STALL_MAX cycles pass without a restart.
module cnt_mon_stall_timer #(
    parameter int STALL_MAX = 64
) (
    input  logic clock,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic stall
);
    localparam int TW = $clog2(STALL_MAX) + 1;
    localparam logic [TW-1:0] LIMIT = TW'(STALL_MAX);
    logic [TW-1:0] timer;
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) timer <= '0;
        else if (restart) timer <= '0;
        else if (run && timer != LIMIT) timer <= timer + TW'(1);
    end
    assign stall = (timer == LIMIT);
endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: checks that an observed up/down counter moves one step at a time in the commanded direction.
// Define CNT_MON_STALL_EN to build in the stall timer; otherwise stall is tied low.
module counter_monitor
    import cnt_mon_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_W     = DEF_ERR_W,
    parameter int STEP_W    = DEF_STEP_W,
    parameter int STALL_MAX = 64
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count,
    input  logic              dir,
    input  logic              cnt_rst_n,
    input  logic              enable,
    input  logic              clr,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [ERR_W-1:0]  err_count,
    output logic [STEP_W-1:0] step_count,
    output logic [WIDTH-1:0]  exp_cnt,
    output logic              stall
);
    state_t state, state_nx;
    logic [WIDTH-1:0] s_cnt, prev, exp_nx;
    logic s_dir, chg, leave, good_step, bad_step;

    assign chg     = (s_cnt != prev);
    assign exp_nx  = WIDTH'(step_expect(32'(prev), s_dir, WIDTH));
    assign leave   = !enable || !cnt_rst_n || (dir != s_dir);
    assign locked  = (state == TRACK);
    assign exp_cnt = locked ? exp_nx : '0;

    // Leaving TRACK masks the step check, so a jump caused by a reset or direction flip is never flagged.
    always_comb begin
        state_nx  = leave ? SYNC : TRACK;
        good_step = locked && !leave && chg && (s_cnt == exp_nx);
        bad_step  = locked && !leave && chg && (s_cnt != exp_nx);
    end

    // prev follows s_cnt in every case: SYNC copies it, and TRACK resyncs to it after good and bad steps alike.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            s_cnt      <= '0;
            s_dir      <= 1'b0;
            prev       <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            step_count <= '0;
        end else begin
            state      <= state_nx;
            s_cnt      <= count;
            s_dir      <= dir;
            prev       <= s_cnt;
            err_pulse  <= bad_step;
            err_sticky <= !clr && (err_sticky || bad_step);
            err_count  <= clr ? '0 : (bad_step && err_count != '1) ? err_count + ERR_W'(1) : err_count;
            step_count <= clr ? '0 : step_count + STEP_W'(good_step);
        end
    end

`ifdef CNT_MON_STALL_EN
    cnt_mon_stall_timer #(.STALL_MAX(STALL_MAX)) u_stall (
        .clock   (clock),
        .rst_n   (rst_n),
        .restart (chg || !locked),
        .run     (locked),
        .stall   (stall)
    );
`else
    logic unused_stall_max;
    assign unused_stall_max = (STALL_MAX != 0);
    assign stall = 1'b0;
`endif
endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: directed stimulus with a cycle-stamped scoreboard of expected output values.
module tb_counter_monitor;
    localparam int S_LOCK = 0, S_PULSE = 1, S_STICKY = 2, S_ERRC = 3;
    localparam int S_STEPC = 4, S_STALL = 5, S_EXP = 6, S_NPULSE = 7;
`ifdef CNT_MON_STALL_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst_n, dir, cnt_rst_n, enable, clr;
    logic [5:0]  count;
    logic        locked, err_pulse, err_sticky, stall;
    logic [7:0]  err_count;
    logic [15:0] step_count;
    logic [5:0]  exp_cnt;

    exp_t sb[$];
    int cyc = 0;
    int pulse_total = 0;
    int checks = 0;
    int errors = 0;

    counter_monitor #(.WIDTH(6), .ERR_W(8), .STEP_W(16), .STALL_MAX(16)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .count      (count),
        .dir        (dir),
        .cnt_rst_n  (cnt_rst_n),
        .enable     (enable),
        .clr        (clr),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .step_count (step_count),
        .exp_cnt    (exp_cnt),
        .stall      (stall)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int pick(input int sel);
        case (sel)
            S_LOCK:   return int'(locked);
            S_PULSE:  return int'(err_pulse);
            S_STICKY: return int'(err_sticky);
            S_ERRC:   return int'(err_count);
            S_STEPC:  return int'(step_count);
            S_STALL:  return int'(stall);
            S_EXP:    return int'(exp_cnt);
            default:  return pulse_total;
        endcase
    endfunction

    // Monitor: on each falling edge, retire every scoreboard entry stamped with the current cycle.
    always @(negedge clock) begin
        int got;
        if (err_pulse) pulse_total = pulse_total + 1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                got = pick(sb[i].sel);
                checks = checks + 1;
                if (sb[i].cyc < cyc || got != sb[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s cycle %0d: got %0d expected %0d", sb[i].name, sb[i].cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_at(input int d, input int sel, input int val, input string name);
        sb.push_back('{cyc + d, sel, val, name});
    endtask

    task automatic expect_reset_values(input string tag);
        expect_at(0, S_LOCK, 0, {tag, "_locked"});
        expect_at(0, S_PULSE, 0, {tag, "_err_pulse"});
        expect_at(0, S_STICKY, 0, {tag, "_err_sticky"});
        expect_at(0, S_ERRC, 0, {tag, "_err_count"});
        expect_at(0, S_STEPC, 0, {tag, "_step_count"});
        expect_at(0, S_STALL, 0, {tag, "_stall"});
        expect_at(0, S_EXP, 0, {tag, "_exp_cnt"});
    endtask

    initial begin
        rst_n = 1'b0; dir = 1'b1; cnt_rst_n = 1'b1; enable = 1'b1; clr = 1'b0; count = 6'd63;
        tick(3);
        expect_reset_values("reset");
        rst_n = 1'b1;
        expect_at(1, S_LOCK, 0, "lock_edge1");
        expect_at(2, S_LOCK, 1, "lock_edge2");
        tick(3);

        // Up sequence 0..63,0 from 63: 65 good steps.
        for (int k = 0; k <= 64; k++) begin
            count = 6'(k);
            if (k == 0) expect_at(1, S_STEPC, 0, "up_latency");
            expect_at(2, S_STEPC, k + 1, "up_step_count");
            expect_at(2, S_LOCK, 1, "up_locked");
            if (k % 16 == 5) expect_at(2, S_EXP, (k + 1) % 64, "up_exp_cnt");
            tick(7);
        end
        expect_at(0, S_ERRC, 0, "up_err_count");
        expect_at(0, S_NPULSE, 0, "up_no_pulse");

        // Down sequence 2,1,0,63,62.
        clr = 1'b1; dir = 1'b0; count = 6'd2;
        expect_at(1, S_STEPC, 0, "clr_step_count");
        expect_at(1, S_LOCK, 0, "down_resync_low");
        expect_at(2, S_LOCK, 1, "down_resync_high");
        tick(1);
        clr = 1'b0;
        tick(6);
        for (int i = 0; i < 4; i++) begin
            count = (i == 0) ? 6'd1 : (i == 1) ? 6'd0 : (i == 2) ? 6'd63 : 6'd62;
            expect_at(2, S_STEPC, i + 1, "down_step_count");
            expect_at(2, S_PULSE, 0, "down_err_pulse");
            tick(7);
        end
        expect_at(0, S_NPULSE, 0, "down_no_pulse");
        expect_at(0, S_ERRC, 0, "down_err_count");

        // Up stream 4,5,7,8 with one bad step.
        clr = 1'b1; dir = 1'b1; count = 6'd4;
        expect_at(1, S_STEPC, 0, "clr2_step_count");
        tick(1);
        clr = 1'b0;
        tick(6);
        count = 6'd5;
        expect_at(2, S_STEPC, 1, "bad_good5");
        tick(7);
        count = 6'd7;
        expect_at(1, S_PULSE, 0, "bad_pulse_early");
        expect_at(2, S_PULSE, 1, "bad_pulse");
        expect_at(2, S_ERRC, 1, "bad_err_count");
        expect_at(2, S_STICKY, 1, "bad_sticky");
        expect_at(2, S_STEPC, 1, "bad_no_step");
        expect_at(3, S_PULSE, 0, "bad_pulse_width");
        tick(7);
        count = 6'd8;
        expect_at(2, S_STEPC, 2, "bad_good8");
        expect_at(2, S_ERRC, 1, "bad_err_hold");
        expect_at(2, S_NPULSE, 1, "bad_one_pulse");
        tick(7);
        clr = 1'b1;
        expect_at(1, S_ERRC, 0, "clr_err_count");
        expect_at(1, S_STICKY, 0, "clr_sticky");
        expect_at(1, S_STEPC, 0, "clr_step");
        tick(1);
        clr = 1'b0;

        // Direction toggle at 10, then 9,8.
        count = 6'd9;
        expect_at(2, S_STEPC, 1, "tog_up9");
        tick(7);
        count = 6'd10;
        expect_at(2, S_STEPC, 2, "tog_up10");
        tick(7);
        dir = 1'b0;
        expect_at(1, S_LOCK, 0, "tog_unlock");
        expect_at(2, S_LOCK, 1, "tog_relock");
        tick(7);
        count = 6'd9;
        expect_at(2, S_STEPC, 3, "tog_down9");
        tick(7);
        count = 6'd8;
        expect_at(2, S_STEPC, 4, "tog_down8");
        expect_at(2, S_NPULSE, 1, "tog_no_pulse");
        tick(7);

        // enable low resyncs to 30, then a counter reset jumps 30 -> 0.
        enable = 1'b0; count = 6'd30;
        expect_at(1, S_LOCK, 0, "en_unlock");
        tick(3);
        enable = 1'b1;
        expect_at(1, S_LOCK, 1, "en_relock");
        tick(6);
        cnt_rst_n = 1'b0; count = 6'd0;
        expect_at(1, S_LOCK, 0, "crst_unlock");
        tick(3);
        cnt_rst_n = 1'b1;
        expect_at(1, S_LOCK, 1, "crst_relock");
        expect_at(1, S_NPULSE, 1, "crst_no_pulse");
        expect_at(1, S_ERRC, 0, "crst_err_count");
        expect_at(1, S_STEPC, 4, "crst_step_count");
        tick(6);

        // Stall: resync to 19 going up, step to 20, hold 25 cycles, step to 21.
        enable = 1'b0; dir = 1'b1; count = 6'd19;
        expect_at(1, S_LOCK, 0, "st_unlock");
        tick(3);
        enable = 1'b1;
        expect_at(1, S_LOCK, 1, "st_relock");
        tick(6);
        count = 6'd20;
        expect_at(2, S_STEPC, 5, "st_step20");
        expect_at(17, S_STALL, 0, "stall_before");
        expect_at(18, S_STALL, ST, "stall_assert");
        expect_at(26, S_STALL, ST, "stall_held");
        tick(25);
        count = 6'd21;
        expect_at(1, S_STALL, ST, "stall_until_edge");
        expect_at(2, S_STALL, 0, "stall_release");
        expect_at(2, S_STEPC, 6, "st_step21");
        tick(7);

        // 300 back-to-back bad steps alternating 0/32 saturate err_count.
        for (int i = 0; i < 300; i++) begin
            count = (i % 2 == 1) ? 6'd32 : 6'd0;
            if (i == 99) expect_at(2, S_ERRC, 100, "sat_err_100");
            if (i == 150) expect_at(2, S_PULSE, 1, "sat_pulse_mid");
            if (i == 254) expect_at(2, S_ERRC, 255, "sat_err_255");
            if (i == 299) begin
                expect_at(2, S_ERRC, 255, "sat_err_hold");
                expect_at(2, S_NPULSE, 301, "sat_pulse_total");
                expect_at(2, S_STICKY, 1, "sat_sticky");
            end
            tick(1);
        end
        for (int i = 0; i < 4; i++) begin
            count = (i % 2 == 1) ? 6'd32 : 6'd0;
            tick(1);
        end
        rst_n = 1'b0; count = 6'd5;
        expect_reset_values("midrst");
        tick(2);
        rst_n = 1'b1;
        expect_at(1, S_LOCK, 0, "rerst_edge1");
        expect_at(2, S_LOCK, 1, "rerst_edge2");
        expect_at(2, S_ERRC, 0, "rerst_err_count");
        expect_at(2, S_PULSE, 0, "rerst_pulse");
        tick(5);

        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
